// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle control unit: FSM state encoding and instruction class.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam int ALU   = 0;
    localparam int STORE = 1;
    localparam int LOAD  = 2;
    localparam int LINK  = 3;
    localparam int BR    = 4;

    typedef struct packed {
        logic br;
        logic link;
        logic load;
        logic store;
        logic alu;
    } cls_t;

    // Reduce the raw decode to one-hot: br > link > load > store > alu.
    function automatic cls_t cls_prio(input cls_t c);
        cls_t r;
        r = '0;
        if (c.br)         r.br    = 1'b1;
        else if (c.link)  r.link  = 1'b1;
        else if (c.load)  r.load  = 1'b1;
        else if (c.store) r.store = 1'b1;
        else if (c.alu)   r.alu   = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-state counter: counts cycles with run high, flags the WAIT_MAX-th such cycle.
module mc_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt_q;

    // The current cycle is itself a wait cycle, so the limit is hit one count early.
    assign expired = run && (cnt_q == CW'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      cnt_q <= '0;
        else if (clr)     cnt_q <= '0;
        else if (run)     cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// IF/ID/EXE/MEM/WB sequencer with SRAM wait-state timeout.
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle and retire counters.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cls_alu,
    input  logic        cls_load,
    input  logic        cls_store,
    input  logic        cls_br,
    input  logic        cls_link,
    input  logic        br_taken,
    input  logic        inst_rdy,
    input  logic        data_rdy,
    output logic [2:0]  state,
    output logic        inst_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        data_req,
    output logic        data_we,
    output logic        rf_we,
    output logic        retire,
    output logic        illegal,
    output logic        bus_err
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_retired
`endif
);
    state_t state_q, state_d;
    cls_t   cls_q, cls_d, cls_id;
    logic   active_q;
    logic   run, clr, expired;

    // active_q holds everything quiet until the first edge after reset release.
    assign cls_id = cls_prio('{br: cls_br, link: cls_link, load: cls_load,
                               store: cls_store, alu: cls_alu});
    assign run    = active_q && ((state_q == S_IF  && !inst_rdy) ||
                                 (state_q == S_MEM && !data_rdy));
    assign clr    = !run || expired;
    assign state  = state_q;

    mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (clr),
        .run     (run),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        inst_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        data_req = 1'b0;
        data_we  = 1'b0;
        rf_we    = 1'b0;
        retire   = 1'b0;
        illegal  = 1'b0;
        bus_err  = 1'b0;
        if (active_q) begin
            case (state_q)
                S_IF: begin
                    inst_req = 1'b1;
                    if (inst_rdy) begin
                        ir_we   = 1'b1;
                        state_d = S_ID;
                    end else if (expired) begin
                        bus_err = 1'b1;
                    end
                end
                S_ID: begin
                    cls_d = cls_id;
                    if (cls_id.br) begin
                        pc_we   = 1'b1;
                        pc_sel  = br_taken;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else if (cls_id == '0) begin
                        illegal = 1'b1;
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_EXE;
                    end
                end
                S_EXE: begin
                    if (cls_q.load || cls_q.store)       state_d = S_MEM;
                    else if (cls_q.br || cls_q == '0)    state_d = S_IF;
                    else                                 state_d = S_WB;
                end
                S_MEM: begin
                    data_req = 1'b1;
                    data_we  = cls_q.store;
                    if (data_rdy) begin
                        if (cls_q.load) begin
                            state_d = S_WB;
                        end else begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_IF;
                        end
                    end else if (expired) begin
                        bus_err = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_IF;
                    end
                end
                S_WB: begin
                    rf_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_sel  = cls_q.link & br_taken;
                    retire  = 1'b1;
                    state_d = S_IF;
                end
                default: state_d = S_IF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IF;
            cls_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            active_q <= 1'b1;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_retired_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_cycles_q  <= '0;
            perf_retired_q <= '0;
        end else begin
            if (active_q) perf_cycles_q  <= perf_cycles_q + 32'd1;
            if (retire)   perf_retired_q <= perf_retired_q + 32'd1;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus wait/timeout/reset sequences.
module tb_multicycle_ctrl;

    logic clk, resetn;
    logic cls_alu, cls_load, cls_store, cls_br, cls_link;
    logic br_taken, inst_rdy, data_rdy;
    logic [2:0] state;
    logic inst_req, ir_we, pc_we, pc_sel, data_req, data_we, rf_we, retire, illegal, bus_err;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_retired;
`endif

    multicycle_ctrl #(.WAIT_MAX(15)) dut (
        .clk(clk), .resetn(resetn),
        .cls_alu(cls_alu), .cls_load(cls_load), .cls_store(cls_store),
        .cls_br(cls_br), .cls_link(cls_link), .br_taken(br_taken),
        .inst_rdy(inst_rdy), .data_rdy(data_rdy), .state(state),
        .inst_req(inst_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .data_req(data_req), .data_we(data_we), .rf_we(rf_we), .retire(retire),
        .illegal(illegal), .bus_err(bus_err)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {inst_req, ir_we, pc_we, pc_sel, data_req, data_we, rf_we, retire, illegal, bus_err}
    logic [9:0] obs;
    assign obs = {inst_req, ir_we, pc_we, pc_sel, data_req, data_we, rf_we, retire, illegal, bus_err};

    typedef struct {
        logic [4:0] cls;   // {br, link, load, store, alu}
        logic       bt;
        logic       irdy;
        logic       drdy;
        logic [2:0] st;
        logic [9:0] o;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic [4:0] c, input logic bt, input logic ir,
                                input logic dr, input logic [2:0] st, input logic [9:0] o);
        vec_t v;
        v.cls = c; v.bt = bt; v.irdy = ir; v.drdy = dr; v.st = st; v.o = o;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [4:0] c, input logic bt, input logic ir, input logic dr,
                       input logic [2:0] st, input logic [9:0] o, input string nm);
        @(negedge clk);
        {cls_br, cls_link, cls_load, cls_store, cls_alu} = c;
        br_taken = bt; inst_rdy = ir; data_rdy = dr;
        #1;
        chk({nm, ".state"}, 32'(state), 32'(st));
        chk({nm, ".outs"},  32'(obs),   32'(o));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        {cls_br, cls_link, cls_load, cls_store, cls_alu} = 5'b00001;
        br_taken = 1'b1; inst_rdy = 1'b1; data_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.outs",  32'(obs),   32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rel.outs", 32'(obs), 32'd0);
    endtask

    localparam logic [9:0] O_IF    = 10'b1100000000;
    localparam logic [9:0] O_IFW   = 10'b1000000000;
    localparam logic [9:0] O_NONE  = 10'b0000000000;
    localparam logic [9:0] O_WB    = 10'b0010001100;
    localparam logic [9:0] O_WBL   = 10'b0011001100;
    localparam logic [9:0] O_BRT   = 10'b0011000100;
    localparam logic [9:0] O_BRN   = 10'b0010000100;
    localparam logic [9:0] O_STOK  = 10'b0010110100;
    localparam logic [9:0] O_STW   = 10'b0000110000;
    localparam logic [9:0] O_STTO  = 10'b0010110001;
    localparam logic [9:0] O_LDW   = 10'b0000100000;
    localparam logic [9:0] O_ILL   = 10'b0010000110;

    initial begin
        // ALU
        tbl.push_back(mk(5'b00001, 0, 1, 1, 3'd0, O_IF));
        tbl.push_back(mk(5'b00001, 0, 1, 1, 3'd1, O_NONE));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd2, O_NONE));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd4, O_WB));
        // beq taken / not taken
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd0, O_IF));
        tbl.push_back(mk(5'b10000, 1, 1, 1, 3'd1, O_BRT));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd0, O_IF));
        tbl.push_back(mk(5'b10000, 0, 1, 1, 3'd1, O_BRN));
        // link, taken in WB
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd0, O_IF));
        tbl.push_back(mk(5'b01000, 0, 1, 1, 3'd1, O_NONE));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd2, O_NONE));
        tbl.push_back(mk(5'b00000, 1, 1, 1, 3'd4, O_WBL));
        // store, zero wait
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd0, O_IF));
        tbl.push_back(mk(5'b00010, 0, 1, 1, 3'd1, O_NONE));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd2, O_NONE));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd3, O_STOK));
        // load, zero wait
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd0, O_IF));
        tbl.push_back(mk(5'b00100, 0, 1, 1, 3'd1, O_NONE));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd2, O_NONE));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd3, O_LDW));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd4, O_WB));
        // priority: br beats load/alu
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd0, O_IF));
        tbl.push_back(mk(5'b10101, 0, 1, 1, 3'd1, O_BRN));
        // priority: link beats load (EXE goes to WB, not MEM)
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd0, O_IF));
        tbl.push_back(mk(5'b01100, 0, 1, 1, 3'd1, O_NONE));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd2, O_NONE));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd4, O_WB));
        // ALU: br_taken in WB must not select the branch target
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd0, O_IF));
        tbl.push_back(mk(5'b00001, 0, 1, 1, 3'd1, O_NONE));
        tbl.push_back(mk(5'b00000, 0, 1, 0, 3'd2, O_NONE));
        tbl.push_back(mk(5'b00000, 1, 1, 1, 3'd4, O_WB));
        // one fetch wait state
        tbl.push_back(mk(5'b00000, 0, 0, 1, 3'd0, O_IFW));
        tbl.push_back(mk(5'b00000, 0, 1, 1, 3'd0, O_IF));
        tbl.push_back(mk(5'b10000, 0, 1, 1, 3'd1, O_BRN));

        do_reset();
        foreach (tbl[i])
            cyc(tbl[i].cls, tbl[i].bt, tbl[i].irdy, tbl[i].drdy, tbl[i].st, tbl[i].o,
                $sformatf("row%0d", i));

        // load with three data wait states: 8 cycles total
        cyc(5'b00000, 0, 1, 1, 3'd0, O_IF, "ldw.if");
        cyc(5'b00100, 0, 1, 1, 3'd1, O_NONE, "ldw.id");
        cyc(5'b00000, 0, 1, 0, 3'd2, O_NONE, "ldw.exe");
        for (int k = 0; k < 3; k++) cyc(5'b00000, 0, 1, 0, 3'd3, O_LDW, "ldw.mem_wait");
        cyc(5'b00000, 0, 1, 1, 3'd3, O_LDW, "ldw.mem_done");
        cyc(5'b00000, 0, 1, 1, 3'd4, O_WB, "ldw.wb");

        // store timeout: bus_err on the 15th wait cycle, no retire
        cyc(5'b00000, 0, 1, 1, 3'd0, O_IF, "sto.if");
        cyc(5'b00010, 0, 1, 1, 3'd1, O_NONE, "sto.id");
        cyc(5'b00000, 0, 1, 0, 3'd2, O_NONE, "sto.exe");
        for (int k = 1; k <= 14; k++) cyc(5'b00000, 0, 1, 0, 3'd3, O_STW, "sto.wait");
        cyc(5'b00000, 0, 1, 0, 3'd3, O_STTO, "sto.timeout");

        // store with ready exactly on the 15th cycle: normal completion
        cyc(5'b00000, 0, 1, 1, 3'd0, O_IF, "st15.if");
        cyc(5'b00010, 0, 1, 1, 3'd1, O_NONE, "st15.id");
        cyc(5'b00000, 0, 1, 0, 3'd2, O_NONE, "st15.exe");
        for (int k = 1; k <= 14; k++) cyc(5'b00000, 0, 1, 0, 3'd3, O_STW, "st15.wait");
        cyc(5'b00000, 0, 1, 1, 3'd3, O_STOK, "st15.done");

        // fetch timeout, refetch restarts the count
        for (int k = 1; k <= 14; k++) cyc(5'b00000, 0, 0, 1, 3'd0, O_IFW, "ifto.wait");
        cyc(5'b00000, 0, 0, 1, 3'd0, 10'b1000000001, "ifto.timeout");
        for (int k = 1; k <= 14; k++) cyc(5'b00000, 0, 0, 1, 3'd0, O_IFW, "ifto.rewait");
        cyc(5'b00000, 0, 1, 1, 3'd0, O_IF, "ifto.fetch");

        // illegal class, then reset mid-MEM
        cyc(5'b00000, 1, 1, 1, 3'd1, O_ILL, "ill.id");
        cyc(5'b00000, 0, 1, 1, 3'd0, O_IF, "mrst.if");
        cyc(5'b00010, 0, 1, 1, 3'd1, O_NONE, "mrst.id");
        cyc(5'b00000, 0, 1, 0, 3'd2, O_NONE, "mrst.exe");
        cyc(5'b00000, 0, 1, 0, 3'd3, O_STW, "mrst.mem");
        #1 resetn = 1'b0;
        #1;
        chk("mrst.state", 32'(state), 32'd0);
        chk("mrst.outs",  32'(obs),   32'd0);

`ifdef MULTICYCLE_CTRL_PERF_EN
        do_reset();
        for (int n = 0; n < 10; n++) begin
            cyc(5'b00000, 0, 1, 1, 3'd0, O_IF, "perf.if");
            cyc(5'b00001, 0, 1, 1, 3'd1, O_NONE, "perf.id");
            cyc(5'b00000, 0, 1, 1, 3'd2, O_NONE, "perf.exe");
            cyc(5'b00000, 0, 1, 1, 3'd4, O_WB, "perf.wb");
        end
        @(negedge clk);
        #1;
        chk("perf_retired", perf_retired, 32'd10);
        chk("perf_cycles",  perf_cycles,  32'd40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
